issue_scoreboard: RTL

- Issue controller between decode and execute in the 8-bit pipelined/OoO CPU.
- Tracks in-flight register writes with per-register countdown timers.
- Holds decode on RAW/WAW hazards, serialises around branches, emits a flush on taken branches, and sequences halt: drain, then assert hlt.

---
 rtl/issue_scoreboard.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Issue controller sitting between decode and execute. It tracks pending
//   register writes with one countdown timer per architectural register.
//   Decode is held on RAW/WAW hazards. Issue is serialised around branches,
//   and a flush is raised when a branch resolves taken. A halt drains all
//   pending writes and then asserts a sticky hlt.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   dec_*           decoded instruction presented by decode
//   br_done/taken   branch resolution pulse from the memory stage
//   issue           instruction accepted into execute this cycle
//   stall           hold fetch/decode registers
//   flush           kill fetch/decode contents (taken branch)
//   hlt             CPU halted, sticky until reset
//   busy_vec        per-register pending-write flags
//
// Build option
//   SCB_FORWARD_EN  When defined, an execute-stage bypass is assumed. A source
//                   register whose timer is at 1 is therefore not a RAW hazard.
//                   WAW checks always use the full busy flag.
module issue_scoreboard #(
  parameter int NUM_REGS  = 4,
  parameter int REG_IDX_W = 2,
  parameter int ALU_LAT   = 3,
  parameter int MEM_LAT   = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_wr_rd,
  input  logic                 dec_is_mem,
  input  logic                 dec_is_br,
  input  logic                 dec_is_hlt,
  input  logic                 br_done,
  input  logic                 br_taken,
  output logic                 issue,
  output logic                 stall,
  output logic                 flush,
  output logic                 hlt,
  output logic [NUM_REGS-1:0]  busy_vec
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BR_WAIT,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t               state_reg, state_next;
  logic                 hlt_reg;
  logic [CNT_W-1:0]     timer_reg [NUM_REGS];
  logic [NUM_REGS-1:0]  src_busy;
  logic                 wr_eff;
  logic                 raw_hazard;
  logic                 waw_hazard;
  logic                 hazard;

  // Branches and halts never write a register, whatever dec_wr_rd says.
  assign wr_eff = dec_wr_rd & ~dec_is_br & ~dec_is_hlt;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_timer
      assign busy_vec[gi] = (timer_reg[gi] != '0);

`ifdef SCB_FORWARD_EN
      // A timer at 1 means the result is in execute and can be bypassed.
      assign src_busy[gi] = (timer_reg[gi] > CNT_W'(1));
`else
      assign src_busy[gi] = busy_vec[gi];
`endif

      // A fresh load takes priority over the running decrement.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer_reg[gi] <= '0;
        end else if (issue && wr_eff && (dec_rd == REG_IDX_W'(gi))) begin
          timer_reg[gi] <= dec_is_mem ? CNT_W'(MEM_LAT) : CNT_W'(ALU_LAT);
        end else if (busy_vec[gi]) begin
          timer_reg[gi] <= timer_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

  assign raw_hazard = (dec_use_rs1 & src_busy[dec_rs1]) |
                      (dec_use_rs2 & src_busy[dec_rs2]);
  assign waw_hazard = wr_eff & busy_vec[dec_rd];
  assign hazard     = raw_hazard | waw_hazard;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      hlt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hlt_reg   <= (state_next == ST_HALTED);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (issue) begin
          // A halt takes precedence over a branch when both flags are set.
          if (dec_is_hlt) begin
            state_next = ST_DRAIN;
          end else if (dec_is_br) begin
            state_next = ST_BR_WAIT;
          end
        end
      end
      ST_BR_WAIT: begin
        if (br_done) begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (busy_vec == '0) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // Outputs. The rst_n terms hold the handshake outputs low during reset.
  always_comb begin
    issue = rst_n & dec_valid & (state_reg == ST_RUN) & ~hazard;
    stall = rst_n & ((dec_valid & ~issue) | (state_reg != ST_RUN));
    flush = rst_n & (state_reg == ST_BR_WAIT) & br_done & br_taken;
    hlt   = hlt_reg;
  end

endmodule
